// File: rtl/csel_adder_pkg.sv
// Shared defaults and types for the pipelined carry-select adder.
// Optional feature macro: CSEL_ADDER_SUB_EN (enables subtract mode in the top).
package csel_adder_pkg;

  localparam int CSEL_WIDTH_DEF = 16;
  localparam int CSEL_BLK_DEF   = 4;

  // Widest block supported; the per-block struct is sized for it so the
  // same type serves every legal BLK value.
  localparam int CSEL_BLK_MAX   = 8;

  // Selected result of one carry-select block.
  typedef struct packed {
    logic [CSEL_BLK_MAX-1:0] sum;
    logic                    cout;
  } csel_blk_res_t;

endpackage

// File: rtl/csel_block.sv
// One BLK-wide carry-select slice: computes the sum for carry-in 0 and for
// carry-in 1 in parallel. The caller picks one with the incoming carry.
module csel_block
  import csel_adder_pkg::*;
#(
  parameter int BLK = CSEL_BLK_DEF
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic           cout0,
  output logic [BLK-1:0] sum1,
  output logic           cout1
);

  logic [BLK:0] res0;
  logic [BLK:0] res1;

  assign res0 = {1'b0, a} + {1'b0, b};
  assign res1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

  assign {cout0, sum0} = res0;
  assign {cout1, sum1} = res1;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Two-stage pipelined carry-select adder with valid/ready handshakes.
// Stage 1 registers the operands; the carry-select adder runs between the
// stages; stage 2 registers sum, carry out and signed overflow.
// Optional feature macro: CSEL_ADDER_SUB_EN -- when defined, sub=1 selects
// A - B; when undefined the sub port is ignored and the block always adds.
// WIDTH must be a multiple of BLK and at least 2*BLK; BLK must be 2..8.
module pipelined_csel_adder
  import csel_adder_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH_DEF,
  parameter int BLK   = CSEL_BLK_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_sum,
  output logic             output_Cout,
  output logic             overflow
);

  localparam int NBLK = WIDTH / BLK;

  // Stage 1 registers
  logic             s1_valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;

  // Stage 2 registers
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  // Combinational adder results feeding stage 2
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;
  logic [NBLK:0]    carry;
  logic             msb_carry_in;

  logic             s1_load;
  logic             s2_load;

  // A stage advances when it is empty or its contents move on this cycle.
  assign s2_load  = !out_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

`ifdef CSEL_ADDER_SUB_EN
  logic sub_reg;

  // Subtraction is A + ~B + 1; Cin plays no part in that mode.
  assign eff_b   = sub_reg ? ~b_reg : b_reg;
  assign eff_cin = sub_reg ? 1'b1 : cin_reg;

  // Mode bit travels alongside the operands through stage 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_reg <= 1'b0;
    end else if (s1_load && in_valid) begin
      sub_reg <= sub;
    end
  end
`else
  // Add-only build: the port stays for interface compatibility but is unused.
  logic unused_sub;
  assign unused_sub = sub;

  assign eff_b   = b_reg;
  assign eff_cin = cin_reg;
`endif

  // Block 0 is selected by the effective carry in; each later block is
  // selected by the carry out of the block below it.
  assign carry[0] = eff_cin;

  genvar gi;
  generate
    for (gi = 0; gi < NBLK; gi++) begin : g_blk
      logic [BLK-1:0] blk_sum0;
      logic [BLK-1:0] blk_sum1;
      logic           blk_cout0;
      logic           blk_cout1;
      csel_blk_res_t  blk_res;

      csel_block #(
        .BLK(BLK)
      ) u_csel_block (
        .a    (a_reg[gi*BLK +: BLK]),
        .b    (eff_b[gi*BLK +: BLK]),
        .sum0 (blk_sum0),
        .cout0(blk_cout0),
        .sum1 (blk_sum1),
        .cout1(blk_cout1)
      );

      assign blk_res.sum  = CSEL_BLK_MAX'(carry[gi] ? blk_sum1 : blk_sum0);
      assign blk_res.cout = carry[gi] ? blk_cout1 : blk_cout0;

      assign sum_next[gi*BLK +: BLK] = blk_res.sum[BLK-1:0];
      assign carry[gi+1]             = blk_res.cout;

      if (BLK < CSEL_BLK_MAX) begin : g_pad
        // Struct padding above BLK is always zero and carries no information.
        logic unused_pad;
        assign unused_pad = ^blk_res.sum[CSEL_BLK_MAX-1:BLK];
      end
    end
  endgenerate

  // Carry into the MSB is recovered from the MSB's own sum bit.
  assign msb_carry_in = sum_next[WIDTH-1] ^ a_reg[WIDTH-1] ^ eff_b[WIDTH-1];
  assign cout_next    = carry[NBLK];
  assign ovf_next     = msb_carry_in ^ carry[NBLK];

  // Pipeline registers: stage 1 captures inputs, stage 2 captures results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg  <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      cin_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          a_reg   <= A;
          b_reg   <= B;
          cin_reg <= Cin;
        end
      end
      if (s2_load) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          sum_reg  <= sum_next;
          cout_reg <= cout_next;
          ovf_reg  <= ovf_next;
        end
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign output_sum  = sum_reg;
  assign output_Cout = cout_reg;
  assign overflow    = ovf_reg;

endmodule
